// File: rtl/mips_mc_pkg.sv
// Shared opcode, FSM-state and ALU-operation definitions for the multi-cycle MIPS core.
package mips_mc_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalted = 3'd5
    } state_e;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAddi = 4'h2;
    localparam logic [3:0] OpLw   = 4'h3;
    localparam logic [3:0] OpSw   = 4'h4;
    localparam logic [3:0] OpJ    = 4'h5;
    localparam logic [3:0] OpXor  = 4'h6;
    localparam logic [3:0] OpOr   = 4'h7;
    localparam logic [3:0] OpAnd  = 4'h8;
    localparam logic [3:0] OpBeq  = 4'h9;
    localparam logic [3:0] OpSlt  = 4'hA;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluXor = 3'd2,
        AluOr  = 3'd3,
        AluAnd = 3'd4,
        AluSlt = 3'd5
    } alu_op_e;

    // Address arithmetic (ADDI/LW/SW) and everything unlisted fall back to add.
    function automatic alu_op_e alu_op_of(logic [3:0] op);
        case (op)
            OpSub:   return AluSub;
            OpXor:   return AluXor;
            OpOr:    return AluOr;
            OpAnd:   return AluAnd;
            OpSlt:   return AluSlt;
            default: return AluAdd;
        endcase
    endfunction

    function automatic logic is_rtype(logic [3:0] op);
        return (op == OpAdd) || (op == OpSub) || (op == OpXor) ||
               (op == OpOr)  || (op == OpAnd) || (op == OpSlt);
    endfunction

    function automatic int unsigned reg_idx(logic [3:0] field, int unsigned reg_n);
        return 32'(field) % reg_n;
    endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Shared instruction/data memory port with a req/ack handshake.
interface mips_mc_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mips_mc_regfile.sv
// REG_N x DATA_W register file: two async read ports, one sync write port, r0 reads as zero.
module mips_mc_regfile
    import mips_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_N  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        raddr1_i,
    input  logic [3:0]        raddr2_i,
    input  logic              we_i,
    input  logic [3:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);
    localparam int unsigned IdxW = (REG_N > 1) ? $clog2(REG_N) : 1;

    logic [DATA_W-1:0] regs_q [REG_N];
    logic [DATA_W-1:0] regs_d [REG_N];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != 4'd0)) begin
            regs_d[IdxW'(waddr_i)] = wdata_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1_o = (raddr1_i == 4'd0) ? '0 : regs_q[IdxW'(raddr1_i)];
    assign rdata2_o = (raddr2_i == 4'd0) ? '0 : regs_q[IdxW'(raddr2_i)];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle 16-bit-ISA MIPS core (FETCH/DECODE/EXEC/MEM/WB) on one shared memory port.
// Define MIPS_MC_ILLEGAL_TRAP_EN to trap undefined opcodes into HALTED instead of running a NOP.
module mips_multicycle_core
    import mips_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned REG_N  = 16
) (
    input  logic              clk,
    input  logic              rst,
    mips_mc_if.master         bus,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;

    logic [3:0]        op, f_a, f_b, f_c, rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] imm_sx, alu_b, alu_y, rf_rdata1, rf_rdata2, rf_wdata;
    logic              rf_we, is_store;

    assign op       = ir_q[15:12];
    assign f_a      = ir_q[11:8];
    assign f_b      = ir_q[7:4];
    assign f_c      = ir_q[3:0];
    assign is_store = (op == OpSw);
    assign rs_idx   = 4'(reg_idx(f_b, REG_N));
    assign rt_idx   = 4'(reg_idx((is_store || op == OpBeq) ? f_a : f_c, REG_N));
    assign rd_idx   = 4'(reg_idx(f_a, REG_N));
    assign imm_sx   = DATA_W'($signed(f_c));
    assign rf_wdata = (op == OpLw) ? mdr_q : alu_q;

    mips_mc_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (rs_idx),
        .raddr2_i (rt_idx),
        .we_i     (rf_we),
        .waddr_i  (rd_idx),
        .wdata_i  (rf_wdata),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    always_comb begin
        alu_b = (op == OpAddi || op == OpLw || is_store) ? imm_sx : b_q;
        case (alu_op_of(op))
            AluSub:  alu_y = a_q - alu_b;
            AluXor:  alu_y = a_q ^ alu_b;
            AluOr:   alu_y = a_q | alu_b;
            AluAnd:  alu_y = a_q & alu_b;
            AluSlt:  alu_y = DATA_W'($signed(a_q) < $signed(alu_b));
            default: alu_y = a_q + alu_b;
        endcase
    end

    // Bus outputs depend only on registered state so the ack path never loops back into them.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_q == StFetch) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc_q;
        end else if (state_q == StMem) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = is_store;
            bus.mem_addr  = alu_q[ADDR_W-1:0];
            bus.mem_wdata = is_store ? b_q : '0;
        end
        if (rst) begin
            bus.mem_req = 1'b0;
        end
    end

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;
        retire  = 1'b0;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            StFetch: begin
                if (bus.mem_ack) begin
                    ir_d    = bus.mem_rdata[15:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = rf_rdata1;
                b_d     = rf_rdata2;
                state_d = StExec;
            end
            StExec: begin
                alu_d = alu_y;
                if (is_rtype(op) || op == OpAddi) begin
                    state_d = StWb;
                end else if (op == OpLw || is_store) begin
                    state_d = StMem;
                end else if (op == OpJ) begin
                    pc_d    = ADDR_W'(ir_q[11:0]);
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (op == OpBeq) begin
                    // pc already points past the branch, so the offset is relative to pc + 1.
                    if (a_q == b_q) begin
                        pc_d = pc_q + ADDR_W'($signed(f_c));
                    end
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (op == OpHalt) begin
                    state_d = StHalted;
                end else begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = StHalted;
`else
                    retire  = 1'b1;
                    state_d = StFetch;
`endif
                end
            end
            StMem: begin
                if (bus.mem_ack) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mdr_d   = bus.mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign pc     = pc_q;
    assign state  = state_q;
    assign halted = (state_q == StHalted);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: directed programs plus random straight-line
// programs checked against an instruction-level model, with a wait-state memory model.
module tb_mips_multicycle_core;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned RN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_mc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    logic [AW-1:0] pc;
    logic [2:0]    state;
    logic          retire, halted, illegal;

    mips_multicycle_core #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .REG_N  (RN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pc      (pc),
        .state   (state),
        .retire  (retire),
        .halted  (halted),
        .illegal (illegal)
    );

    int n_vec = 0;
    int n_err = 0;

    // Memory: preloaded image plus a write overlay; ack after `waits` request cycles.
    logic [DW-1:0]    init_mem [256];
    logic [DW-1:0]    wr_mem   [256];
    logic             wr_vld   [256];
    logic             mem_clr = 1'b0;
    int               waits = 0;
    int               wcnt  = 0;
    int               cyc   = 0;
    logic [AW+DW-1:0] wr_log[$];
    logic [AW-1:0]    fetch_log[$];
    int               ret_t[$];

    assign bus.mem_ack   = bus.mem_req && (wcnt >= waits);
    assign bus.mem_rdata = wr_vld[bus.mem_addr] ? wr_mem[bus.mem_addr] : init_mem[bus.mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (retire) ret_t.push_back(cyc);
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) wr_vld[i] <= 1'b0;
        end
        if (bus.mem_req && bus.mem_ack) begin
            wcnt <= 0;
            if (bus.mem_we) begin
                wr_mem[bus.mem_addr] <= bus.mem_wdata;
                wr_vld[bus.mem_addr] <= 1'b1;
                wr_log.push_back({bus.mem_addr, bus.mem_wdata});
            end else if (state == 3'd0) begin
                fetch_log.push_back(bus.mem_addr);
            end
        end else if (bus.mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the core in reset at a negedge with an all-zero memory image.
    task automatic begin_test(input int w);
        rst     = 1'b1;
        waits   = w;
        mem_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        for (int i = 0; i < 256; i++) init_mem[i] = '0;
        wr_log.delete();
        fetch_log.delete();
        ret_t.delete();
    endtask

    task automatic run_until_halt(input int max, output int cycles);
        cycles = 0;
        while (!halted && cycles < max) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    function automatic logic [DW-1:0] rf(input int i);
        return dut.u_regfile.regs_q[i];
    endfunction

    task automatic test_reset();
        begin_test(0);
        init_mem[0] = 32'h0000_F000;
        #1;
        n_vec++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, pc, state, retire, halted,
             illegal} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h pc=%h state=%0d ret=%b halt=%b ill=%b, required all zero",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, pc, state, retire,
                     halted, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h, required req=1 addr=00", bus.mem_req,
                     bus.mem_addr);
        end
    endtask

    task automatic test_alu_seq();
        int c;
        logic [DW-1:0] exp_r [5];
        begin_test(0);
        init_mem[0] = 32'h2105;
        init_mem[1] = 32'h220D;
        init_mem[2] = 32'h0312;
        init_mem[3] = 32'hA421;
        init_mem[4] = 32'hF000;
        exp_r = '{32'd0, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1};
        rst = 1'b0;
        run_until_halt(100, c);
        n_vec++;
        if (c !== 19) begin
            n_err++;
            $display("FAIL alu_halt_cycle: got %0d, required 19", c);
        end
        for (int r = 1; r < 5; r++) begin
            n_vec++;
            if (rf(r) !== exp_r[r]) begin
                n_err++;
                $display("FAIL alu_reg r%0d: got %h, required %h", r, rf(r), exp_r[r]);
            end
        end
        n_vec++;
        if (ret_t.size() !== 4) begin
            n_err++;
            $display("FAIL alu_retires: got %0d, required 4", ret_t.size());
        end
    endtask

    task automatic test_load_store();
        int c;
        begin_test(2);
        init_mem[0]     = 32'h3108;
        init_mem[1]     = 32'h4104;
        init_mem[2]     = 32'h3504;
        init_mem[3]     = 32'hF000;
        init_mem[8'hF8] = 32'h1234;
        rst = 1'b0;
        run_until_halt(200, c);
        n_vec++;
        if (c !== 31) begin
            n_err++;
            $display("FAIL ls_halt_cycle: got %0d, required 31", c);
        end
        n_vec++;
        if (wr_log.size() !== 1) begin
            n_err++;
            $display("FAIL ls_write_count: got %0d, required 1", wr_log.size());
        end else begin
            n_vec++;
            if (wr_log[0] !== {8'h04, 32'h1234}) begin
                n_err++;
                $display("FAIL ls_write: got addr/data %h, required 0400001234", wr_log[0]);
            end
        end
        n_vec++;
        if (rf(5) !== 32'h1234) begin
            n_err++;
            $display("FAIL ls_r5: got %h, required 00001234", rf(5));
        end
        n_vec++;
        if (ret_t.size() !== 3) begin
            n_err++;
            $display("FAIL ls_retires: got %0d, required 3", ret_t.size());
        end else begin
            n_vec++;
            if ((ret_t[1] - ret_t[0]) !== 8 || (ret_t[2] - ret_t[1]) !== 9) begin
                n_err++;
                $display("FAIL ls_latency: sw=%0d lw=%0d, required sw=8 lw=9",
                         ret_t[1] - ret_t[0], ret_t[2] - ret_t[1]);
            end
        end
    endtask

    task automatic test_branch();
        logic [AW-1:0] exp_f [4];
        // BEQ r0, r0, -1 spins on itself.
        begin_test(0);
        init_mem[0] = 32'h2101;
        init_mem[1] = 32'h900F;
        rst = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        n_vec++;
        if (fetch_log.size() !== 7 || ret_t.size() !== 7) begin
            n_err++;
            $display("FAIL beq_counts: fetches=%0d retires=%0d, required 7 and 7",
                     fetch_log.size(), ret_t.size());
        end
        for (int i = 1; i < fetch_log.size(); i++) begin
            n_vec++;
            if (fetch_log[i] !== 8'h01) begin
                n_err++;
                $display("FAIL beq_loop fetch %0d: got %h, required 01", i, fetch_log[i]);
            end
        end
        // J 0xFFF truncates to 0xFF, then the sequential fetch wraps to 0.
        begin_test(0);
        init_mem[0]     = 32'h5FFF;
        init_mem[8'hFF] = 32'h2603;
        exp_f = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        rst = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        n_vec++;
        if (fetch_log.size() !== 4) begin
            n_err++;
            $display("FAIL jump_fetch_count: got %0d, required 4", fetch_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (fetch_log[i] !== exp_f[i]) begin
                    n_err++;
                    $display("FAIL jump_wrap fetch %0d: got %h, required %h", i, fetch_log[i],
                             exp_f[i]);
                end
            end
        end
        n_vec++;
        if (rf(6) !== 32'd3) begin
            n_err++;
            $display("FAIL jump_r6: got %h, required 00000003", rf(6));
        end
    endtask

    task automatic test_r0_width();
        int c;
        begin_test(0);
        init_mem[0] = 32'h2007;
        init_mem[1] = 32'h2201;
        init_mem[2] = 32'h1102;
        init_mem[3] = 32'h0302;
        init_mem[4] = 32'hF000;
        rst = 1'b0;
        run_until_halt(100, c);
        n_vec++;
        if (rf(0) !== '0 || rf(3) !== 32'd1) begin
            n_err++;
            $display("FAIL r0_zero: r0=%h r3=%h, required r0=0 r3=1", rf(0), rf(3));
        end
        n_vec++;
        if (rf(1) !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL sub_wrap: got %h, required ffffffff", rf(1));
        end
    endtask

    task automatic test_reset_mid_lw();
        int c;
        int k;
        begin_test(6);
        init_mem[0]     = 32'h3508;
        init_mem[1]     = 32'hF000;
        init_mem[8'hF8] = 32'hABCD;
        rst = 1'b0;
        k = 0;
        while (state !== 3'd3 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL rst_reach_mem: state=%0d, required 3", state);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.mem_req, pc, state} !== '0 || rf(5) !== '0) begin
            n_err++;
            $display("FAIL rst_mid_lw: req=%b pc=%h state=%0d r5=%h, required all zero",
                     bus.mem_req, pc, state, rf(5));
        end
        @(negedge clk);
        rst = 1'b0;
        run_until_halt(100, c);
        n_vec++;
        if (rf(5) !== 32'hABCD) begin
            n_err++;
            $display("FAIL rst_rerun_r5: got %h, required 0000abcd", rf(5));
        end
    endtask

    task automatic test_illegal();
        int c;
        logic exp_ill;
        int exp_ret;
        int exp_cyc;
        logic [DW-1:0] exp_r2;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        exp_ill = 1'b1; exp_ret = 1; exp_cyc = 7;  exp_r2 = 32'd0;
`else
        exp_ill = 1'b0; exp_ret = 3; exp_cyc = 14; exp_r2 = 32'd2;
`endif
        begin_test(0);
        init_mem[0] = 32'h2101;
        init_mem[1] = 32'hB000;
        init_mem[2] = 32'h2202;
        init_mem[3] = 32'hF000;
        rst = 1'b0;
        run_until_halt(100, c);
        n_vec++;
        if (illegal !== exp_ill || halted !== 1'b1 || c !== exp_cyc) begin
            n_err++;
            $display("FAIL illegal_flags: ill=%b halt=%b cyc=%0d, required ill=%b halt=1 cyc=%0d",
                     illegal, halted, c, exp_ill, exp_cyc);
        end
        n_vec++;
        if (ret_t.size() !== exp_ret || rf(2) !== exp_r2) begin
            n_err++;
            $display("FAIL illegal_effect: retires=%0d r2=%h, required %0d and %h",
                     ret_t.size(), rf(2), exp_ret, exp_r2);
        end
    endtask

    // Random straight-line programs; LW/SW use r0 + negative imm, so data stays in F8..FF.
    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [DW-1:0]    mregs [16];
            logic [DW-1:0]    mmem  [256];
            logic [AW+DW-1:0] exp_wr[$];
            logic [15:0]      insn;
            logic [DW-1:0]    a, b, res, simm;
            logic [3:0]       rd, rs, rt, imm;
            logic [AW-1:0]    addr;
            int w, n, kind, exp_cyc, c;
            w = $urandom_range(0, 3);
            n = $urandom_range(4, 20);
            begin_test(w);
            for (int i = 0; i < 16; i++) mregs[i] = '0;
            for (int i = 248; i < 256; i++) begin
                mmem[i]     = $urandom;
                init_mem[i] = mmem[i];
            end
            exp_cyc = 0;
            for (int p = 0; p < n; p++) begin
                kind = $urandom_range(0, 8);
                rd   = 4'($urandom_range(0, 15));
                rs   = 4'($urandom_range(0, 15));
                rt   = 4'($urandom_range(0, 15));
                imm  = (kind >= 7) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 15));
                simm = {{(DW-4){imm[3]}}, imm};
                a    = mregs[rs];
                b    = mregs[rt];
                addr = AW'(simm);
                res  = '0;
                case (kind)
                    0: begin insn = {4'h0, rd, rs, rt}; res = a + b; end
                    1: begin insn = {4'h1, rd, rs, rt}; res = a - b; end
                    2: begin insn = {4'h6, rd, rs, rt}; res = a ^ b; end
                    3: begin insn = {4'h7, rd, rs, rt}; res = a | b; end
                    4: begin insn = {4'h8, rd, rs, rt}; res = a & b; end
                    5: begin insn = {4'hA, rd, rs, rt}; res = ($signed(a) < $signed(b)) ? 1 : 0; end
                    6: begin insn = {4'h2, rd, rs, imm}; res = a + simm; end
                    7: begin insn = {4'h3, rd, 4'h0, imm}; res = mmem[addr]; end
                    default: begin
                        insn = {4'h4, rt, 4'h0, imm};
                        mmem[addr] = b;
                        exp_wr.push_back({addr, b});
                    end
                endcase
                if (kind <= 7 && rd != 4'd0) mregs[rd] = res;
                exp_cyc += (kind == 7) ? 5 + 2 * w : (kind == 8) ? 4 + 2 * w : 4 + w;
                init_mem[p] = {16'h0, insn};
            end
            init_mem[n] = 32'hF000;
            exp_cyc += 3 + w;
            rst = 1'b0;
            run_until_halt(exp_cyc + 50, c);
            n_vec++;
            if (c !== exp_cyc || ret_t.size() !== n) begin
                n_err++;
                $display("FAIL rand%0d timing: cycles=%0d retires=%0d, required %0d and %0d",
                         it, c, ret_t.size(), exp_cyc, n);
            end
            for (int r = 1; r < 16; r++) begin
                n_vec++;
                if (rf(r) !== mregs[r]) begin
                    n_err++;
                    $display("FAIL rand%0d reg r%0d: got %h, required %h", it, r, rf(r),
                             mregs[r]);
                end
            end
            n_vec++;
            if (wr_log.size() !== exp_wr.size()) begin
                n_err++;
                $display("FAIL rand%0d write_count: got %0d, required %0d", it, wr_log.size(),
                         exp_wr.size());
            end else begin
                for (int i = 0; i < exp_wr.size(); i++) begin
                    n_vec++;
                    if (wr_log[i] !== exp_wr[i]) begin
                        n_err++;
                        $display("FAIL rand%0d write %0d: got %h, required %h", it, i,
                                 wr_log[i], exp_wr[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_load_store();
        test_branch();
        test_r0_width();
        test_reset_mid_lw();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
